// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares one single-port MEM_DEPTH x 8 RAM between the SPI command stream and a host port.
//   SPI words (din[9:8]) 00 load write address, 01 write data, 10 load read address, 11 issue read.
//   SPI accesses go through a one-entry pending slot because SPI cannot stall; the host uses req/gnt.
// Ports: clk, rst_n (sync, active-low);
//   SPI side spi_rx_valid/spi_din in, spi_dout/spi_tx_valid/spi_ovf out;
//   host side host_req/we/addr/wdata in, host_gnt/rdata/rvalid out;
//   RAM side mem_en/we/addr/wdata out, mem_rdata in (registered, one cycle after a read); busy out.
// Optional macro ARB_ROUND_ROBIN_EN: SPI/host ties alternate. Without it, SPI always wins ties.
module spi_ram_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_rx_valid,
  input  logic [9:0]           spi_din,
  output logic [7:0]           spi_dout,
  output logic                 spi_tx_valid,
  output logic                 spi_ovf,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic [7:0]           host_rdata,
  output logic                 host_rvalid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 busy
);

  // Addresses are ADDR_SIZE bits and simply wrap; a deeper MEM_DEPTH than the
  // address space can reach leaves the upper words unused. Nothing to build.
  if (MEM_DEPTH > (1 << ADDR_SIZE)) begin : g_depth_beyond_addr_space
  end

  typedef enum logic [1:0] {IDLE, SPI_ACC, HOST_ACC, RD_WAIT} state_t;

  state_t state, state_nxt;
  logic   grant_spi, grant_host;

  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 pend_vld, pend_we;
  logic [ADDR_SIZE-1:0] pend_addr;
  logic [7:0]           pend_data;
  logic                 rd_for_host;

  // din[8] set means a RAM access (01 write, 11 read); clear means an address load.
  logic spi_access;
  assign spi_access = spi_rx_valid & spi_din[8];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_host;   // last grant went to the host; reset as host so SPI wins the first tie
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_spi  = 1'b0;
    grant_host = 1'b0;
    case (state)
      IDLE: begin
        if (pend_vld && host_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          grant_spi  = last_host;
          grant_host = !last_host;
`else
          grant_spi  = 1'b1;
`endif
        end else if (pend_vld) begin
          grant_spi  = 1'b1;
        end else if (host_req) begin
          grant_host = 1'b1;
        end
        if (grant_spi)       state_nxt = SPI_ACC;
        else if (grant_host) state_nxt = HOST_ACC;
      end
      // mem_we holds the registered winner's direction during the access cycle.
      SPI_ACC, HOST_ACC: state_nxt = mem_we ? IDLE : RD_WAIT;
      RD_WAIT:           state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // SPI decode and pending slot. The slot frees on the same edge it is granted,
  // so a word arriving on that edge refills it instead of overflowing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      rd_addr   <= '0;
      pend_vld  <= 1'b0;
      pend_we   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      spi_ovf   <= 1'b0;
    end else begin
      if (grant_spi) pend_vld <= 1'b0;
      if (spi_rx_valid && !spi_din[8]) begin
        if (spi_din[9]) rd_addr <= spi_din[ADDR_SIZE-1:0];
        else            wr_addr <= spi_din[ADDR_SIZE-1:0];
      end
      if (spi_access) begin
        if (pend_vld && !grant_spi) begin
          spi_ovf <= 1'b1;
        end else begin
          pend_vld  <= 1'b1;
          pend_we   <= !spi_din[9];
          pend_addr <= spi_din[9] ? rd_addr : wr_addr;
          pend_data <= spi_din[7:0];
        end
      end
    end
  end

  // RAM command register and read-return path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      host_gnt     <= 1'b0;
      rd_for_host  <= 1'b0;
      spi_dout     <= '0;
      spi_tx_valid <= 1'b0;
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
    end else begin
      mem_en       <= 1'b0;
      host_gnt     <= 1'b0;
      spi_tx_valid <= 1'b0;
      host_rvalid  <= 1'b0;
      if (grant_spi) begin
        mem_en      <= 1'b1;
        mem_we      <= pend_we;
        mem_addr    <= pend_addr;
        mem_wdata   <= pend_data;
        rd_for_host <= 1'b0;
      end else if (grant_host) begin
        mem_en      <= 1'b1;
        mem_we      <= host_we;
        mem_addr    <= host_addr;
        mem_wdata   <= host_wdata;
        host_gnt    <= 1'b1;
        rd_for_host <= 1'b1;
      end
      if (state == RD_WAIT) begin
        if (rd_for_host) begin
          host_rdata  <= mem_rdata;
          host_rvalid <= 1'b1;
        end else begin
          spi_dout     <= mem_rdata;
          spi_tx_valid <= 1'b1;
        end
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                      last_host <= 1'b1;
    else if (grant_spi || grant_host) last_host <= grant_host;
  end
`endif

endmodule
